// File: rtl/gsim_pkg.sv
// Shared constants, state encoding and accumulator sizing for the GSIM
// banded Gauss-Seidel solver.
package gsim_pkg;

    localparam int C1   = 13;
    localparam int C2   = 6;
    localparam int C3   = 1;
    localparam int DIAG = 20;

    localparam int ACC_GUARD = 8;

    function automatic int acc_width(input int x_w);
        return x_w + ACC_GUARD;
    endfunction

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        OUT
    } gsim_state_t;

endpackage

// File: rtl/gsim_row_pe.sv
// Combinational row update: 7-tap banded dot product, floor division by the
// diagonal, saturation to X_W and the magnitude of the change.
module gsim_row_pe
    import gsim_pkg::*;
#(
    parameter int B_W  = 16,
    parameter int X_W  = 32,
    parameter int FRAC = 16
) (
    input  logic signed [B_W-1:0] b,
    input  logic signed [X_W-1:0] x_m1,
    input  logic signed [X_W-1:0] x_p1,
    input  logic signed [X_W-1:0] x_m2,
    input  logic signed [X_W-1:0] x_p2,
    input  logic signed [X_W-1:0] x_m3,
    input  logic signed [X_W-1:0] x_p3,
    input  logic        [5:0]     tap_en,
    input  logic signed [X_W-1:0] x_old,
    output logic signed [X_W-1:0] x_new,
    output logic        [X_W-1:0] delta
);

    localparam int A_W = acc_width(X_W);

    localparam logic signed [A_W-1:0] K1   = A_W'(C1);
    localparam logic signed [A_W-1:0] K2   = A_W'(C2);
    localparam logic signed [A_W-1:0] K3   = A_W'(C3);
    localparam logic signed [A_W-1:0] KD   = A_W'(DIAG);
    localparam logic signed [A_W-1:0] ONE  = A_W'(1);
    localparam logic signed [A_W-1:0] XMAX = {{(A_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [A_W-1:0] XMIN = {{(A_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

    function automatic logic signed [A_W-1:0] tap(input logic en, input logic signed [X_W-1:0] v);
        return en ? A_W'(v) : '0;
    endfunction

    logic signed [A_W-1:0] s;
    logic signed [A_W-1:0] q;
    logic signed [A_W-1:0] rem;
    logic signed [X_W:0]   dif;
    logic        [X_W:0]   mag;

    always_comb begin
        s = (A_W'(b) <<< FRAC)
          + K1 * (tap(tap_en[0], x_m1) + tap(tap_en[1], x_p1))
          - K2 * (tap(tap_en[2], x_m2) + tap(tap_en[3], x_p2))
          + K3 * (tap(tap_en[4], x_m3) + tap(tap_en[5], x_p3));

        // Native division truncates toward zero; step down for negative remainders.
        q   = s / KD;
        rem = s % KD;
        if (rem != '0 && s[A_W-1])
            q = q - ONE;

        if (q > XMAX)
            x_new = XMAX[X_W-1:0];
        else if (q < XMIN)
            x_new = XMIN[X_W-1:0];
        else
            x_new = q[X_W-1:0];

        dif   = (X_W+1)'(x_new) - (X_W+1)'(x_old);
        mag   = dif[X_W] ? -dif : dif;
        delta = mag[X_W] ? '1 : mag[X_W-1:0];
    end

endmodule

// File: rtl/gsim_solver_p.sv
// Banded Gauss-Seidel solver: streams in b, sweeps in place one row per cycle,
// stops on iteration count or tolerance, streams x out with backpressure.
module gsim_solver_p
    import gsim_pkg::*;
#(
    parameter int N      = 16,
    parameter int B_W    = 16,
    parameter int X_W    = 32,
    parameter int FRAC   = 16,
    parameter int ITER_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [B_W-1:0]    b_in,
    input  logic        [ITER_W-1:0] cfg_iter,
    input  logic                     cfg_tol_en,
    input  logic        [X_W-1:0]    cfg_tol,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [X_W-1:0]    x_out,
    output logic                     out_last,
    output logic        [ITER_W-1:0] iter_used
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0]  LAST     = IDX_W'(N-1);
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);

    gsim_state_t state, state_nxt;

    logic signed [B_W-1:0] b_mem [N];
    logic signed [X_W-1:0] x_mem [N];

    logic [IDX_W-1:0]  load_idx, row, out_idx;
    logic [ITER_W-1:0] sweep, cfg_iter_q;
    logic              tol_en_q;
    logic [X_W-1:0]    tol_q, maxd, maxd_row;

    logic signed [X_W-1:0] x_lo [3];
    logic signed [X_W-1:0] x_hi [3];
    logic [2:0]            lo_ok, hi_ok;
    logic signed [X_W-1:0] x_new;
    logic [X_W-1:0]        delta;
    logic                  load_fire, row_last, calc_exit;

    // Out-of-range neighbours read a harmless in-range slot; the PE masks them.
    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            lo_ok[k] = int'(row) > int'(k);
            hi_ok[k] = int'(row) + int'(k) + 1 < N;
            x_lo[k]  = x_mem[lo_ok[k] ? row - IDX_W'(k + 1) : row];
            x_hi[k]  = x_mem[hi_ok[k] ? row + IDX_W'(k + 1) : row];
        end
    end

    gsim_row_pe #(
        .B_W  (B_W),
        .X_W  (X_W),
        .FRAC (FRAC)
    ) u_row_pe (
        .b      (b_mem[row]),
        .x_m1   (x_lo[0]),
        .x_p1   (x_hi[0]),
        .x_m2   (x_lo[1]),
        .x_p2   (x_hi[1]),
        .x_m3   (x_lo[2]),
        .x_p3   (x_hi[2]),
        .tap_en ({hi_ok[2], lo_ok[2], hi_ok[1], lo_ok[1], hi_ok[0], lo_ok[0]}),
        .x_old  (x_mem[row]),
        .x_new  (x_new),
        .delta  (delta)
    );

    assign load_fire = in_valid && (state == LOAD);
    assign row_last  = (row == LAST);
    assign maxd_row  = (delta > maxd) ? delta : maxd;
    assign calc_exit = (sweep + ITER_ONE == cfg_iter_q) || (tol_en_q && maxd_row <= tol_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        x_out     = '0;
        iter_used = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (load_fire && load_idx == LAST)
                    state_nxt = (cfg_iter_q == '0) ? OUT : CALC;
            end
            CALC: begin
                if (row_last && calc_exit)
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                x_out     = x_mem[out_idx];
                iter_used = sweep;
                out_last  = (out_idx == LAST);
                if (out_ready && out_idx == LAST)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                b_mem[i] <= '0;
                x_mem[i] <= '0;
            end
            load_idx   <= '0;
            row        <= '0;
            out_idx    <= '0;
            sweep      <= '0;
            cfg_iter_q <= '0;
            tol_en_q   <= 1'b0;
            tol_q      <= '0;
            maxd       <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        b_mem[load_idx] <= b_in;
                        x_mem[load_idx] <= '0;
                        if (load_idx == '0) begin
                            cfg_iter_q <= cfg_iter;
                            tol_en_q   <= cfg_tol_en;
                            tol_q      <= cfg_tol;
                        end
                        if (load_idx == LAST) begin
                            load_idx <= '0;
                            row      <= '0;
                            sweep    <= '0;
                            maxd     <= '0;
                            out_idx  <= '0;
                        end else begin
                            load_idx <= load_idx + IDX_W'(1);
                        end
                    end
                end
                CALC: begin
                    x_mem[row] <= x_new;
                    if (row_last) begin
                        sweep <= sweep + ITER_ONE;
                        row   <= '0;
                        maxd  <= '0;
                    end else begin
                        row  <= row + IDX_W'(1);
                        maxd <= maxd_row;
                    end
                end
                OUT: begin
                    if (out_ready)
                        out_idx <= (out_idx == LAST) ? '0 : out_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_solver_p.sv
// Directed scoreboard bench for gsim_solver_p: a floor-division reference model
// pushes expected beats, the output collector pops and asserts them.
module tb_gsim_solver_p;

    localparam int N      = 16;
    localparam int B_W    = 16;
    localparam int X_W    = 32;
    localparam int FRAC   = 16;
    localparam int ITER_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [B_W-1:0]    b_in = '0;
    logic        [ITER_W-1:0] cfg_iter = '0;
    logic                     cfg_tol_en = 1'b0;
    logic        [X_W-1:0]    cfg_tol = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [X_W-1:0]    x_out;
    logic                     out_last;
    logic        [ITER_W-1:0] iter_used;

    always #5 clk = ~clk;

    gsim_solver_p #(
        .N      (N),
        .B_W    (B_W),
        .X_W    (X_W),
        .FRAC   (FRAC),
        .ITER_W (ITER_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .b_in       (b_in),
        .cfg_iter   (cfg_iter),
        .cfg_tol_en (cfg_tol_en),
        .cfg_tol    (cfg_tol),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x_out      (x_out),
        .out_last   (out_last),
        .iter_used  (iter_used)
    );

    typedef struct {
        logic signed [X_W-1:0]    x;
        logic                     last;
        logic        [ITER_W-1:0] it;
    } beat_t;

    int ncomp = 0;
    int nfail = 0;
    beat_t sbq[$];
    int exp_lat;
    logic signed [B_W-1:0]    bv [N];
    logic signed [X_W-1:0]    got_x [N];
    logic        [ITER_W-1:0] got_iter;
    logic        [ITER_W-1:0] it2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain Gauss-Seidel on 64-bit integers with explicit floor.
    task automatic model(input int iter, input bit tol_en, input longint tol);
        longint x [N];
        int     cf [4] = '{0, 13, -6, 1};
        int     sw = 0;
        longint s, q, d, maxd, lo, hi;
        beat_t  e;
        for (int i = 0; i < N; i++) x[i] = 0;
        while (sw < iter) begin
            maxd = 0;
            for (int r = 0; r < N; r++) begin
                s = longint'(bv[r]) * 65536;
                for (int k = 1; k <= 3; k++) begin
                    lo = (r - k >= 0) ? x[r-k] : 0;
                    hi = (r + k < N)  ? x[r+k] : 0;
                    s += cf[k] * (lo + hi);
                end
                q = (s >= 0) ? s / 20 : -((-s + 19) / 20);
                if (q > 64'sd2147483647)  q = 64'sd2147483647;
                if (q < -64'sd2147483648) q = -64'sd2147483648;
                d = q - x[r];
                if (d < 0) d = -d;
                if (d > 64'sd4294967295) d = 64'sd4294967295;
                if (d > maxd) maxd = d;
                x[r] = q;
            end
            sw++;
            if (tol_en && maxd <= tol) break;
        end
        for (int i = 0; i < N; i++) begin
            e.x    = X_W'(x[i]);
            e.last = (i == N - 1);
            e.it   = ITER_W'(sw);
            sbq.push_back(e);
        end
        exp_lat = N * sw;
    endtask

    task automatic load(input logic [ITER_W-1:0] it, input bit ten, input logic [X_W-1:0] tol, input bit gaps);
        int k = 0;
        int cyc = 0;
        while (k < N && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (gaps && cyc % 2 == 0) begin
                in_valid = 1'b0;
                b_in     = B_W'($urandom);
            end else begin
                in_valid   = 1'b1;
                b_in       = bv[k];
                cfg_iter   = (k == 0) ? it : ITER_W'($urandom);
                cfg_tol_en = (k == 0) ? ten : 1'($urandom);
                cfg_tol    = (k == 0) ? tol : X_W'($urandom);
                if (in_ready) k++;
            end
        end
        chk("load_beats", 64'(k), 64'(N));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit bp);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat = 0;
        int n = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic signed [X_W-1:0]    px = '0;
        logic                     pl = 1'b0;
        logic        [ITER_W-1:0] pi = '0;
        beat_t e;
        @(negedge clk);
        while (!out_valid && lat < 5000) begin
            chk("calc_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
            lat++;
        end
        chk("calc_latency", 64'(lat), 64'(exp_lat));
        while (n < N && cyc < 1000 && sbq.size() > 0) begin
            if (!out_valid) begin
                chk("out_valid_held", 64'(out_valid), 64'(1));
                break;
            end
            e = sbq[0];
            chk($sformatf("x_out[%0d]", n), 64'(x_out), 64'(e.x));
            chk($sformatf("out_last[%0d]", n), 64'(out_last), 64'(e.last));
            chk($sformatf("iter_used[%0d]", n), 64'(iter_used), 64'(e.it));
            if (held) begin
                chk("stall_x", 64'(x_out), 64'(px));
                chk("stall_last", 64'(out_last), 64'(pl));
                chk("stall_iter", 64'(iter_used), 64'(pi));
            end
            out_ready = bp ? pat[cyc % 4] : 1'b1;
            held = !out_ready;
            px = x_out;
            pl = out_last;
            pi = iter_used;
            if (out_ready) begin
                got_x[n] = x_out;
                got_iter = iter_used;
                void'(sbq.pop_front());
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("out_beats", 64'(n), 64'(N));
        chk("post_in_ready", 64'(in_ready), 64'(1));
        chk("post_out_valid", 64'(out_valid), 64'(0));
        sbq.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_x_out", 64'(x_out), 64'(0));
        chk("rst_iter_used", 64'(iter_used), 64'(0));
        rst_n = 1'b1;

        // Reset during the third sweep aborts the problem.
        for (int i = 0; i < N; i++) bv[i] = B_W'($urandom);
        load(8'd10, 1'b0, '0, 1'b0);
        repeat (40) @(negedge clk);
        chk("mid_calc_out_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_idle_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < N; i++) bv[i] = '0;
        model(5, 1'b0, 0);
        load(8'd5, 1'b0, '0, 1'b0);
        collect(1'b0);

        // Single sweep with a known closed-form result.
        for (int i = 0; i < N; i++) bv[i] = '0;
        bv[0] = 16'sd20;
        bv[1] = 16'sd20;
        model(1, 1'b0, 0);
        load(8'd1, 1'b0, '0, 1'b0);
        collect(1'b0);
        chk("one_sweep_x0", 64'(got_x[0]), 64'h0001_0000);
        chk("one_sweep_x1", 64'(got_x[1]), 64'h0001_A666);
        chk("one_sweep_iter", 64'(got_iter), 64'(1));

        // Early exit on zero tolerance, then a fixed-count rerun.
        for (int i = 0; i < N; i++) bv[i] = 16'sd20;
        model(200, 1'b1, 0);
        load(8'd200, 1'b1, '0, 1'b0);
        collect(1'b0);
        it2 = got_iter;
        model(int'(it2), 1'b0, 0);
        load(it2, 1'b0, '0, 1'b0);
        collect(1'b0);

        // Non-zero tolerance on random data.
        for (int i = 0; i < N; i++) bv[i] = B_W'($urandom);
        model(200, 1'b1, 5000);
        load(8'd200, 1'b1, 32'd5000, 1'b0);
        collect(1'b0);

        // Output backpressure.
        for (int i = 0; i < N; i++) bv[i] = B_W'($urandom);
        model(3, 1'b0, 0);
        load(8'd3, 1'b0, '0, 1'b0);
        collect(1'b1);

        // Zero iterations.
        for (int i = 0; i < N; i++) bv[i] = B_W'($urandom);
        model(0, 1'b0, 0);
        load(8'd0, 1'b0, '0, 1'b0);
        collect(1'b0);

        // Full-scale negative b, gapless and gapped loads.
        for (int i = 0; i < N; i++) bv[i] = -16'sd32768;
        model(10, 1'b0, 0);
        load(8'd10, 1'b0, '0, 1'b0);
        collect(1'b0);
        model(10, 1'b0, 0);
        load(8'd10, 1'b0, '0, 1'b1);
        collect(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/gsim_solver_p.md
Name: gsim_solver_p

Overview:
- Parametrised Gauss-Seidel iterative solver for the banded system used by the GSIM engine: diagonal 20, off-diagonals -13 (|i-j|=1), 6 (|i-j|=2), -1 (|i-j|=3).
- Accepts N right-hand-side values over a valid/ready stream, then runs in-place sweeps, one row update per cycle.
- Stops after a runtime-configured iteration count, or earlier when an optional convergence tolerance is met.
- Streams N solution values out with backpressure. Successor to the fixed N=16, fixed-iteration GSIM block.

Parameters:
- N, 16, number of unknowns (>=4).
- B_W, 16, signed width of b.
- X_W, 32, signed width of x in fixed point.
- FRAC, 16, fractional bits of x.
- ITER_W, 8, width of the iteration count and iteration-used fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  b beat valid.
- in_ready  out  1  solver can accept a b beat.
- b_in  in  B_W  signed b_i, streamed i=0..N-1.
- cfg_iter  in  ITER_W  maximum sweeps; sampled on beat 0.
- cfg_tol_en  in  1  enable early exit; sampled on beat 0.
- cfg_tol  in  X_W  unsigned tolerance on max |delta x| per sweep; sampled on beat 0.
- out_valid  out  1  x_out valid.
- out_ready  in  1  downstream accepts.
- x_out  out  X_W  signed Qx.FRAC x_i, streamed i=0..N-1.
- out_last  out  1  asserted with x_{N-1}.
- iter_used  out  ITER_W  sweeps actually performed; valid while out_valid.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state LOAD, in_ready=1, out_valid=0, out_last=0, x_out=0, iter_used=0.
  - Clears the x array, the b array and all counters.
  - Mid-operation reset aborts the current problem with no further output.
- State LOAD:
  - in_ready=1. A beat transfers when in_valid&in_ready.
  - Beat k writes b[k] and clears x[k] to 0.
  - Beat 0 latches the cfg_* fields.
  - After beat N-1, go to CALC with row=0, sweep=0. If latched cfg_iter==0, go straight to OUT (all x=0, iter_used=0).
- State CALC:
  - in_ready=0, out_valid=0.
  - Each cycle computes row r: s = (sext(b[r])<<FRAC) + 13*(x[r-1]+x[r+1]) - 6*(x[r-2]+x[r+2]) + (x[r-3]+x[r+3]). Out-of-range x terms are 0.
  - x_new = floor(s/20), signed, rounding toward -infinity, saturated to X_W signed. x[r] <= x_new at the clock edge.
  - Gauss-Seidel ordering: rows below r already hold this sweep's values.
  - s is computed at X_W+8 bits, so no intermediate overflow.
  - The block tracks maxd = max |x_new - x_old| over the sweep, using a saturating unsigned X_W compare.
  - At r=N-1: sweep+1. Go to OUT if the new sweep count == cfg_iter, or if cfg_tol_en and maxd <= cfg_tol. Otherwise r=0, maxd=0.
  - A CALC pass takes exactly N*sweeps cycles.
- State OUT:
  - out_valid=1 starting the cycle after the last CALC row.
  - x_out=x[idx] and iter_used=sweeps; out_last=(idx==N-1).
  - idx advances only on out_valid&out_ready. With out_ready low, x_out, out_last and iter_used stay stable.
  - The transfer of the last beat returns to LOAD. in_ready=1 on the next cycle; there is no overlap between problems.
- in_valid while not in LOAD is ignored. b_in and cfg_* are don't-care when not transferring.

Decomposition:
- Shared package gsim_pkg holds:
  - coefficient constants C1=13, C2=6, C3=1, DIAG=20;
  - state encoding LOAD/CALC/OUT;
  - helper widths X_W+8 for the accumulator.
- One sub-module, gsim_row_pe: a combinational 7-tap row datapath. Inputs are b, the six neighbour x values with per-tap zero masks, and x_old. Outputs are saturated x_new and |delta|.
- Top-level owns the FSM, the register arrays and the stream handshakes.

Test Plan:
1. Reset mid-CALC (rst_n low 2 cycles during sweep 3) -> in_ready=1, out_valid=0; a new problem with all b=0 and cfg_iter=5 returns 16 beats of x=0, iter_used=5.
2. cfg_iter=1, b0=20, b1=20, other b=0, N=16 -> x_out[0]=0x00010000, x_out[1]=0x0001A666 (floor(2162688/20)=108134), iter_used=1, out_last only on beat 15.
3. All b=20, cfg_iter=200, cfg_tol_en=1, cfg_tol=0 -> terminates with iter_used<200; the final sweep has zero change, and a rerun with cfg_iter equal to the reported iter_used gives identical x.
4. Backpressure: out_ready toggles 1,0,0,1 pattern -> exactly 16 transfers, in order, with no duplicated or dropped index; x_out held stable while out_ready=0.
5. cfg_iter=0, any b -> no CALC cycles; 16 zero beats, iter_used=0.
6. Extreme b: all b=-32768, cfg_iter=10 -> no wrap; each x equals a reference model using floor division with saturation. in_valid gaps during LOAD (valid low every other cycle) give results identical to a gapless load.
